// File: rtl/iic_cfg_seq_if.sv
// AXI4-Lite register bus between iic_cfg_seq (master) and the AXI IIC core s_axi port (slave).
interface iic_cfg_seq_if;
    logic [8:0]  m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [8:0]  m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid,
        input  m_arready, m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid,
        output m_arready, m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/iic_cfg_seq.sv
// Sequences the AXI IIC core through single-byte I2C register writes (dev/reg/data) using
// dynamic-mode TX_FIFO writes, status polling and ISR clean-up, one AXI4-Lite access at a time.
module iic_cfg_seq #(
    parameter int unsigned POLL_MAX  = 1024,
    parameter logic [31:0] SOFTR_KEY = 32'h0000000A
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic       err,
    output logic       busy,
    iic_cfg_seq_if.master m_axi
);

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    localparam logic [AW-1:0] A_ISR   = 9'h020;
    localparam logic [AW-1:0] A_SOFTR = 9'h040;
    localparam logic [AW-1:0] A_CR    = 9'h100;
    localparam logic [AW-1:0] A_SR    = 9'h104;
    localparam logic [AW-1:0] A_TXF   = 9'h108;

    typedef enum logic [3:0] {
        S_INIT_SOFTR, S_INIT_CR, S_IDLE, S_PRE_POLL, S_TX0, S_TX1, S_TX2,
        S_POST_POLL, S_RD_ISR, S_CLR_ISR, S_DONE
    } state_t;

    typedef enum logic [1:0] {T_IDLE, T_ADDR, T_RESP, T_READ} txn_t;

    state_t          r_state;
    txn_t            r_txn;
    logic            r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [AW-1:0]   r_awaddr, r_araddr;
    logic [DW-1:0]   r_wdata;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg, r_data;
    logic [DW-1:0]   r_isr;
    logic            r_axi_err, r_timeout;
    logic [PW-1:0]   r_poll_cnt;
    logic            r_cmd_ready, r_busy, r_done, r_err;

    logic            w_bus_state, w_is_rd;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic            w_aw_hs, w_w_hs, w_ar_hs, w_aw_clr, w_w_clr;
    logic            w_b_done, w_r_done, w_resp_err, w_err_any, w_sr_ok, w_poll_last;

    // Access issued by each bus-owning state
    always_comb begin
        w_bus_state = 1'b1;
        w_is_rd     = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        unique case (r_state)
            S_INIT_SOFTR: begin w_addr = A_SOFTR; w_wdata = SOFTR_KEY; end
            S_INIT_CR:    begin w_addr = A_CR;    w_wdata = DW'(1); end
            S_PRE_POLL,
            S_POST_POLL:  begin w_addr = A_SR;    w_is_rd = 1'b1; end
            S_TX0:        begin w_addr = A_TXF;   w_wdata = DW'({2'b01, r_dev, 1'b0}); end
            S_TX1:        begin w_addr = A_TXF;   w_wdata = DW'(r_reg); end
            S_TX2:        begin w_addr = A_TXF;   w_wdata = DW'({2'b10, r_data}); end
            S_RD_ISR:     begin w_addr = A_ISR;   w_is_rd = 1'b1; end
            S_CLR_ISR:    begin w_addr = A_ISR;   w_wdata = r_isr & DW'(3); end
            default:      w_bus_state = 1'b0;
        endcase
    end

    assign w_aw_hs     = r_awvalid & m_axi.m_awready;
    assign w_w_hs      = r_wvalid & m_axi.m_wready;
    assign w_ar_hs     = r_arvalid & m_axi.m_arready;
    assign w_aw_clr    = ~r_awvalid | w_aw_hs;
    assign w_w_clr     = ~r_wvalid | w_w_hs;
    assign w_b_done    = r_bready & m_axi.m_bvalid;
    assign w_r_done    = r_rready & m_axi.m_rvalid;
    assign w_resp_err  = (w_b_done & (m_axi.m_bresp != 2'b00)) |
                         (w_r_done & (m_axi.m_rresp != 2'b00));
    assign w_err_any   = r_axi_err | w_resp_err;
    // Ready to start: bus not busy and TX FIFO empty
    assign w_sr_ok     = ~m_axi.m_rdata[2] & m_axi.m_rdata[7];
    assign w_poll_last = (r_poll_cnt == PW'(POLL_MAX - 1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_INIT_SOFTR;
            r_txn       <= T_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_data      <= '0;
            r_isr       <= '0;
            r_axi_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_poll_cnt  <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_resp_err) r_axi_err <= 1'b1;

            // Single-outstanding AXI engine; a new access starts the cycle after the last completes
            unique case (r_txn)
                T_IDLE: if (w_bus_state) begin
                    if (w_is_rd) begin
                        r_araddr  <= w_addr;
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
                        r_txn     <= T_READ;
                    end else begin
                        r_awaddr  <= w_addr;
                        r_wdata   <= w_wdata;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_txn     <= T_ADDR;
                    end
                end
                T_ADDR: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_aw_clr && w_w_clr) begin
                        r_bready <= 1'b1;
                        r_txn    <= T_RESP;
                    end
                end
                T_RESP: if (w_b_done) begin
                    r_bready <= 1'b0;
                    r_txn    <= T_IDLE;
                end
                T_READ: begin
                    if (w_ar_hs) r_arvalid <= 1'b0;
                    if (w_r_done) begin
                        r_rready <= 1'b0;
                        r_txn    <= T_IDLE;
                    end
                end
                default: r_txn <= T_IDLE;
            endcase

            case (r_state)
                S_INIT_SOFTR: if (w_b_done) r_state <= S_INIT_CR;
                S_INIT_CR: if (w_b_done) begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                S_IDLE: if (cmd_valid && r_cmd_ready) begin
                    r_dev       <= cmd_dev;
                    r_reg       <= cmd_reg;
                    r_data      <= cmd_data;
                    r_axi_err   <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_isr       <= '0;
                    r_poll_cnt  <= '0;
                    r_cmd_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    r_state     <= S_PRE_POLL;
                end
                S_PRE_POLL, S_POST_POLL: if (w_r_done) begin
                    r_poll_cnt <= r_poll_cnt + PW'(1);
                    if (w_err_any) begin
                        r_state <= S_DONE;
                    end else if (w_sr_ok) begin
                        r_state <= (r_state == S_PRE_POLL) ? S_TX0 : S_RD_ISR;
                    end else if (w_poll_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_TX0: if (w_b_done) r_state <= w_err_any ? S_DONE : S_TX1;
                S_TX1: if (w_b_done) r_state <= w_err_any ? S_DONE : S_TX2;
                S_TX2: if (w_b_done) begin
                    r_poll_cnt <= '0;
                    r_state    <= w_err_any ? S_DONE : S_POST_POLL;
                end
                S_RD_ISR: if (w_r_done) begin
                    r_isr <= m_axi.m_rdata;
                    if (!w_err_any && (m_axi.m_rdata[1:0] != 2'b00)) r_state <= S_CLR_ISR;
                    else                                              r_state <= S_DONE;
                end
                S_CLR_ISR: if (w_b_done) r_state <= S_DONE;
                S_DONE: begin
                    r_done <= 1'b1;
                    r_err  <= r_axi_err | r_timeout | (r_isr[1:0] != 2'b00);
                    // A timed-out poll re-enables the core before taking new commands
                    if (r_timeout) begin
                        r_state <= S_INIT_CR;
                    end else begin
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_INIT_SOFTR;
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign m_axi.m_awaddr  = r_awaddr;
    assign m_axi.m_awvalid = r_awvalid;
    assign m_axi.m_wdata   = r_wdata;
    assign m_axi.m_wstrb   = 4'hF;
    assign m_axi.m_wvalid  = r_wvalid;
    assign m_axi.m_bready  = r_bready;
    assign m_axi.m_araddr  = r_araddr;
    assign m_axi.m_arvalid = r_arvalid;
    assign m_axi.m_rready  = r_rready;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Scoreboard bench for iic_cfg_seq: an AXI-Lite slave model of the IIC core checks every access
// and every done/err pulse against expectations queued when each command is issued.
module tb_iic_cfg_seq;

    localparam int unsigned TB_POLL_MAX = 4;

    typedef struct {
        bit          wr;
        logic [8:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       cmd_valid, cmd_ready, done, err, busy;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg, cmd_data;

    iic_cfg_seq_if bus ();

    iic_cfg_seq #(.POLL_MAX(TB_POLL_MAX), .SOFTR_KEY(32'h0000000A)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dev  (cmd_dev),
        .cmd_reg  (cmd_reg),
        .cmd_data (cmd_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .m_axi    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    txn_t        sb_q[$];
    bit          done_q[$];
    logic [31:0] sr_q[$];

    int          aw_delay = 0;
    bit          berr_en = 1'b0;
    logic [31:0] berr_data = '0;
    logic [31:0] sr_default = 32'h80;
    logic [31:0] isr_val = '0;

    int n_writes = 0, n_done = 0, sr_reads = 0, b_hs_cnt = 0;
    int lst_aw_cyc = 0, lst_w_cyc = 0, cur_aw_cyc = 0, cur_w_cyc = 0, aw_wait = 0;
    int exp_done = 0;
    bit got_aw = 1'b0, got_w = 1'b0;
    logic [8:0]  s_awaddr;
    logic [31:0] s_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input bit wr, input logic [8:0] addr, input logic [31:0] data);
        txn_t t;
        chk("sb_access_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            t = sb_q.pop_front();
            chk("access_kind_wr", 32'(wr), 32'(t.wr));
            chk("access_addr", 32'(addr), 32'(t.addr));
            if (wr) chk("access_wdata", data, t.data);
        end
    endtask

    task automatic push_w(input logic [8:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = 1'b1; t.addr = a; t.data = d;
        sb_q.push_back(t);
    endtask

    task automatic push_r(input logic [8:0] a);
        txn_t t;
        t.wr = 1'b0; t.addr = a; t.data = '0;
        sb_q.push_back(t);
    endtask

    task automatic push_done(input bit e);
        done_q.push_back(e);
        exp_done++;
    endtask

    task automatic push_init();
        push_w(9'h040, 32'h0000000A);
        push_w(9'h100, 32'h00000001);
    endtask

    // Full successful-path access list for one command
    task automatic push_cmd_ok(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dt,
                               input int n_pre, input logic [1:0] isr);
        for (int i = 0; i < n_pre; i++) push_r(9'h104);
        push_w(9'h108, 32'h100 + 32'(dev) * 2);
        push_w(9'h108, 32'(rg));
        push_w(9'h108, 32'h200 + 32'(dt));
        push_r(9'h104);
        push_r(9'h020);
        if (isr != 2'b00) push_w(9'h020, 32'(isr));
        push_done(isr != 2'b00);
    endtask

    task automatic wait_ready(input int max_cyc);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < max_cyc) begin
            @(posedge clk); #2;
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (n_done < exp_done && n < max_cyc) begin
            @(posedge clk); #2;
            n++;
        end
        chk("done_count", 32'(n_done), 32'(exp_done));
    endtask

    task automatic send_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dt);
        wait_ready(200);
        cmd_dev   = dev;
        cmd_reg   = rg;
        cmd_data  = dt;
        cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    // IIC core slave model: samples handshakes at the edge, drives responses 1 time unit later
    initial begin : slave_p
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [8:0]  aw_a, ar_a;
        logic [31:0] w_d;
        bus.m_awready = 1'b0; bus.m_wready = 1'b1; bus.m_bresp = 2'b00; bus.m_bvalid = 1'b0;
        bus.m_arready = 1'b1; bus.m_rdata = '0; bus.m_rresp = 2'b00; bus.m_rvalid = 1'b0;
        forever begin
            @(posedge clk);
            aw_hs = bus.m_awvalid & bus.m_awready;
            w_hs  = bus.m_wvalid & bus.m_wready;
            b_hs  = bus.m_bvalid & bus.m_bready;
            ar_hs = bus.m_arvalid & bus.m_arready;
            r_hs  = bus.m_rvalid & bus.m_rready;
            aw_a  = bus.m_awaddr;
            w_d   = bus.m_wdata;
            ar_a  = bus.m_araddr;
            #1;
            if (!aresetn) begin
                bus.m_awready = 1'b0; bus.m_bvalid = 1'b0; bus.m_rvalid = 1'b0;
                got_aw = 1'b0; got_w = 1'b0; aw_wait = 0; cur_aw_cyc = 0; cur_w_cyc = 0;
            end else begin
                if (b_hs) begin bus.m_bvalid = 1'b0; b_hs_cnt++; end
                if (r_hs) bus.m_rvalid = 1'b0;
                if (aw_hs) begin got_aw = 1'b1; s_awaddr = aw_a; lst_aw_cyc = cur_aw_cyc; cur_aw_cyc = 0; end
                if (w_hs)  begin got_w = 1'b1;  s_wdata = w_d;   lst_w_cyc = cur_w_cyc;   cur_w_cyc = 0;  end
                if (bus.m_awvalid) cur_aw_cyc++;
                if (bus.m_wvalid)  cur_w_cyc++;
                if (bus.m_awvalid) begin
                    bus.m_awready = (aw_wait >= aw_delay);
                    aw_wait++;
                end else begin
                    bus.m_awready = 1'b0;
                    aw_wait = 0;
                end
                if (got_aw && got_w) begin
                    sb_pop(1'b1, s_awaddr, s_wdata);
                    bus.m_bresp = (berr_en && s_awaddr == 9'h108 && s_wdata == berr_data) ? 2'b10 : 2'b00;
                    bus.m_bvalid = 1'b1;
                    got_aw = 1'b0; got_w = 1'b0;
                    n_writes++;
                end
                if (ar_hs) begin
                    sb_pop(1'b0, ar_a, '0);
                    if (ar_a == 9'h104) begin
                        if (sr_q.size() != 0) bus.m_rdata = sr_q.pop_front();
                        else                  bus.m_rdata = sr_default;
                        sr_reads++;
                    end else if (ar_a == 9'h020) begin
                        bus.m_rdata = isr_val;
                    end else begin
                        bus.m_rdata = '0;
                    end
                    bus.m_rresp  = 2'b00;
                    bus.m_rvalid = 1'b1;
                end
                if (done === 1'b1) begin
                    chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                    if (done_q.size() != 0) chk("done_err", 32'(err), 32'(done_q.pop_front()));
                    n_done++;
                end
            end
        end
    end

    initial begin : main_p
        int w0, r0, b0;
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_dev = '0; cmd_reg = '0; cmd_data = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_awvalid", 32'(bus.m_awvalid), 32'd0);
        chk("rst_wvalid", 32'(bus.m_wvalid), 32'd0);
        chk("rst_arvalid", 32'(bus.m_arvalid), 32'd0);
        chk("rst_bready", 32'(bus.m_bready), 32'd0);
        chk("rst_awaddr", 32'(bus.m_awaddr), 32'd0);
        chk("rst_wdata", bus.m_wdata, 32'd0);

        push_init();
        @(negedge clk); aresetn = 1'b1;
        wait_ready(100);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("init_writes", 32'(n_writes), 32'd2);
        chk("wstrb", 32'(bus.m_wstrb), 32'hF);

        // Basic command: no ISR write expected
        w0 = n_writes;
        push_cmd_ok(7'h50, 8'h12, 8'hA5, 1, 2'b00);
        send_cmd(7'h50, 8'h12, 8'hA5);
        wait_done(300);
        chk("basic_write_cnt", 32'(n_writes - w0), 32'd3);

        // Slow awready, immediate wready; new cmd_valid while busy must be ignored
        aw_delay = 3;
        b0 = b_hs_cnt;
        push_cmd_ok(7'h1C, 8'h34, 8'h5A, 1, 2'b00);
        send_cmd(7'h1C, 8'h34, 8'h5A);
        cmd_dev = 7'h11; cmd_reg = 8'h22; cmd_data = 8'h33; cmd_valid = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("busy_flag", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        wait_done(400);
        chk("aw_valid_cycles", 32'(lst_aw_cyc), 32'd4);
        chk("w_valid_cycles", 32'(lst_w_cyc), 32'd1);
        chk("b_handshakes", 32'(b_hs_cnt - b0), 32'd3);
        aw_delay = 0;

        // Bus busy three times before ready
        sr_q.push_back(32'h84); sr_q.push_back(32'h84); sr_q.push_back(32'h84); sr_q.push_back(32'h80);
        r0 = sr_reads;
        push_cmd_ok(7'h2A, 8'h01, 8'hFF, 4, 2'b00);
        send_cmd(7'h2A, 8'h01, 8'hFF);
        wait_done(400);
        chk("prepoll_sr_reads", 32'(sr_reads - r0), 32'd5);

        // Poll timeout: re-enable core, then idle
        sr_default = 32'h04;
        r0 = sr_reads; w0 = n_writes;
        for (int i = 0; i < int'(TB_POLL_MAX); i++) push_r(9'h104);
        push_w(9'h100, 32'h1);
        push_done(1'b1);
        send_cmd(7'h33, 8'h44, 8'h55);
        wait_done(300);
        wait_ready(100);
        chk("timeout_sr_reads", 32'(sr_reads - r0), 32'd4);
        chk("timeout_writes", 32'(n_writes - w0), 32'd1);
        sr_default = 32'h80;

        // No-ack in ISR: clear it and report error
        isr_val = 32'h2;
        w0 = n_writes;
        push_cmd_ok(7'h50, 8'h12, 8'hA5, 1, 2'b10);
        send_cmd(7'h50, 8'h12, 8'hA5);
        wait_done(300);
        chk("isr_write_cnt", 32'(n_writes - w0), 32'd4);
        isr_val = 32'h0;

        // Slave error on TX1: TX2 must not be issued
        berr_en = 1'b1; berr_data = 32'h0000_0077;
        w0 = n_writes;
        push_r(9'h104);
        push_w(9'h108, 32'h100 + 32'(7'h21) * 2);
        push_w(9'h108, 32'h77);
        push_done(1'b1);
        send_cmd(7'h21, 8'h77, 8'h99);
        wait_done(300);
        chk("berr_write_cnt", 32'(n_writes - w0), 32'd2);
        berr_en = 1'b0;

        // Sticky error does not leak into the next command
        push_cmd_ok(7'h7F, 8'h00, 8'h00, 1, 2'b00);
        send_cmd(7'h7F, 8'h00, 8'h00);
        wait_done(300);

        // Reset while a write address is stalled
        aw_delay = 50;
        push_r(9'h104);
        send_cmd(7'h05, 8'h06, 8'h07);
        for (int i = 0; i < 50 && bus.m_awvalid !== 1'b1; i++) begin @(posedge clk); #2; end
        chk("stall_awvalid", 32'(bus.m_awvalid), 32'd1);
        @(negedge clk); aresetn = 1'b0;
        #1;
        chk("midrst_awvalid", 32'(bus.m_awvalid), 32'd0);
        chk("midrst_wvalid", 32'(bus.m_wvalid), 32'd0);
        chk("midrst_bready", 32'(bus.m_bready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        aw_delay = 0;
        repeat (2) @(posedge clk);
        push_init();
        @(negedge clk); aresetn = 1'b1;
        wait_ready(100);

        push_cmd_ok(7'h50, 8'hC3, 8'h3C, 1, 2'b00);
        send_cmd(7'h50, 8'hC3, 8'h3C);
        wait_done(300);
        repeat (5) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
